// File: rtl/hlpte_seq_ctrl.sv
// HLPTE top-level sequencer: frame load, parameter capture,
// four-block job dispatch to the core and result streaming.
module hlpte_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_data,
    input  logic [7:0]  data,
    input  logic        in_valid_param,
    input  logic [3:0]  index,
    input  logic        mode,
    input  logic [4:0]  QP,
    output logic        out_valid,
    output logic [31:0] out_value,
    output logic        mem_we,
    output logic [13:0] mem_waddr,
    output logic [7:0]  mem_wdata,
    output logic        core_start,
    output logic [3:0]  core_frame,
    output logic [1:0]  core_blk,
    output logic        core_mode,
    output logic [4:0]  core_qp,
    input  logic        core_done,
    output logic [9:0]  rbuf_raddr,
    input  logic [31:0] rbuf_rdata,
    output logic        busy,
    output logic        proto_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WPAR  = 3'd2;
    localparam logic [2:0] S_PARAM = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_WDONE = 3'd5;
    localparam logic [2:0] S_OUT   = 3'd6;

    localparam logic [13:0] LAST_PIX = 14'h3FFF;
    localparam logic [10:0] OUT_END  = 11'd1025;

    logic [2:0]  state_q, state_d;
    logic [13:0] pix_cnt_q, pix_cnt_d;
    logic [1:0]  beat_cnt_q, beat_cnt_d;
    logic [1:0]  blk_cnt_q, blk_cnt_d;
    logic [3:0]  set_cnt_q, set_cnt_d;
    logic [10:0] out_cnt_q, out_cnt_d;
    logic [3:0]  mode_q, mode_d;
    logic [3:0]  index_q, index_d;
    logic [4:0]  qp_q, qp_d;
    logic        mem_we_q, mem_we_d;
    logic [13:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        core_start_q, core_start_d;
    logic [3:0]  core_frame_q, core_frame_d;
    logic [1:0]  core_blk_q, core_blk_d;
    logic        core_mode_q, core_mode_d;
    logic [4:0]  core_qp_q, core_qp_d;
    logic        rd_vld_q, rd_vld_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_value_q, out_value_d;
    logic        proto_err_q, proto_err_d;
    logic        data_ok, param_ok;

    assign data_ok  = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign param_ok = (state_q == S_WPAR) || (state_q == S_PARAM);

    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        blk_cnt_d    = blk_cnt_q;
        set_cnt_d    = set_cnt_q;
        out_cnt_d    = out_cnt_q;
        mode_d       = mode_q;
        index_d      = index_q;
        qp_d         = qp_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        core_start_d = 1'b0;
        core_frame_d = core_frame_q;
        core_blk_d   = core_blk_q;
        core_mode_d  = core_mode_q;
        core_qp_d    = core_qp_q;
        rd_vld_d     = 1'b0;
        // Result path: one cycle of RAM latency plus this output register
        out_valid_d  = rd_vld_q;
        out_value_d  = rd_vld_q ? rbuf_rdata : 32'd0;
        proto_err_d  = proto_err_q;

        if (in_valid_data && !data_ok) begin
            proto_err_d = 1'b1;
        end
        if (in_valid_param && !param_ok) begin
            proto_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (in_valid_data) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = pix_cnt_q;
                    mem_wdata_d = data;
                    pix_cnt_d   = pix_cnt_q + 14'd1;
                    state_d     = (pix_cnt_q == LAST_PIX) ? S_WPAR : S_LOAD;
                end
            end
            S_WPAR: begin
                if (in_valid_param) begin
                    index_d    = index;
                    qp_d       = QP;
                    mode_d     = {mode, mode_q[2:0]};
                    beat_cnt_d = 2'd1;
                    state_d    = S_PARAM;
                end
            end
            S_PARAM: begin
                if (in_valid_param) begin
                    mode_d[2'd3 - beat_cnt_q] = mode;
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    if (beat_cnt_q == 2'd3) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                core_start_d = 1'b1;
                core_blk_d   = blk_cnt_q;
                core_mode_d  = mode_q[2'd3 - blk_cnt_q];
                core_frame_d = index_q;
                core_qp_d    = qp_q;
                state_d      = S_WDONE;
            end
            S_WDONE: begin
                if (core_done) begin
                    if (blk_cnt_q == 2'd3) begin
                        blk_cnt_d = 2'd0;
                        out_cnt_d = 11'd0;
                        state_d   = S_OUT;
                    end else begin
                        blk_cnt_d = blk_cnt_q + 2'd1;
                        state_d   = S_RUN;
                    end
                end
            end
            S_OUT: begin
                rd_vld_d  = ~out_cnt_q[10];
                out_cnt_d = out_cnt_q + 11'd1;
                if (out_cnt_q == OUT_END) begin
                    out_cnt_d = 11'd0;
                    set_cnt_d = set_cnt_q + 4'd1;
                    state_d   = (set_cnt_q == 4'd15) ? S_IDLE : S_WPAR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pix_cnt_q    <= '0;
            beat_cnt_q   <= '0;
            blk_cnt_q    <= '0;
            set_cnt_q    <= '0;
            out_cnt_q    <= '0;
            mode_q       <= '0;
            index_q      <= '0;
            qp_q         <= '0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            core_start_q <= 1'b0;
            core_frame_q <= '0;
            core_blk_q   <= '0;
            core_mode_q  <= 1'b0;
            core_qp_q    <= '0;
            rd_vld_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_value_q  <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            blk_cnt_q    <= blk_cnt_d;
            set_cnt_q    <= set_cnt_d;
            out_cnt_q    <= out_cnt_d;
            mode_q       <= mode_d;
            index_q      <= index_d;
            qp_q         <= qp_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_start_q <= core_start_d;
            core_frame_q <= core_frame_d;
            core_blk_q   <= core_blk_d;
            core_mode_q  <= core_mode_d;
            core_qp_q    <= core_qp_d;
            rd_vld_q     <= rd_vld_d;
            out_valid_q  <= out_valid_d;
            out_value_q  <= out_value_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_value  = out_value_q;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_start = core_start_q;
    assign core_frame = core_frame_q;
    assign core_blk   = core_blk_q;
    assign core_mode  = core_mode_q;
    assign core_qp    = core_qp_q;
    assign rbuf_raddr = out_cnt_q[9:0];
    assign busy       = (state_q != S_IDLE) && (state_q != S_WPAR);
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_hlpte_seq_ctrl.sv
// Bench for hlpte_seq_ctrl: table plus random parameter sets,
// core and result-buffer models, write/job/burst scoreboards.
module tb_hlpte_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_data;
    logic [7:0]  data;
    logic        in_valid_param;
    logic [3:0]  index;
    logic        mode;
    logic [4:0]  QP;
    logic        out_valid;
    logic [31:0] out_value;
    logic        mem_we;
    logic [13:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        core_start;
    logic [3:0]  core_frame;
    logic [1:0]  core_blk;
    logic        core_mode;
    logic [4:0]  core_qp;
    logic        core_done = 1'b0;
    logic [9:0]  rbuf_raddr;
    logic [31:0] rbuf_rdata = 32'd0;
    logic        busy;
    logic        proto_err;

    hlpte_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid_data(in_valid_data), .data(data),
        .in_valid_param(in_valid_param), .index(index),
        .mode(mode), .QP(QP),
        .out_valid(out_valid), .out_value(out_value),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .core_start(core_start), .core_frame(core_frame),
        .core_blk(core_blk), .core_mode(core_mode), .core_qp(core_qp),
        .core_done(core_done),
        .rbuf_raddr(rbuf_raddr), .rbuf_rdata(rbuf_rdata),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] idx;
        logic [4:0] qp;
        logic [3:0] beats;
        logic [3:0] gaps;
        logic [3:0] exp_mode;
        logic       proto;
    } set_vec_t;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int tmr = 0;
    int done_cnt = 0;
    int nb_done = 0;
    int zero_bad = 0;
    bit in_burst = 0;
    int cur_start, cur_len, cur_bad;
    logic [31:0] cur_first, cur_last;
    logic [21:0] wr_q[$];
    logic [11:0] jobs_q[$];
    int done4_q[$];
    int b_start[$], b_len[$], b_bad[$];
    logic [31:0] b_first[$], b_last[$];

    // Result buffer: burst b holds i - 512 + 4096*b
    always @(posedge clk)
        rbuf_rdata <= 32'(int'(rbuf_raddr) - 512 + 4096 * nb_done);

    always @(negedge clk) begin
        cyc++;
        if (mem_we) wr_q.push_back({mem_waddr, mem_wdata});
        if (core_start)
            jobs_q.push_back({core_blk, core_mode, core_frame, core_qp});
        if (out_valid) begin
            if (!in_burst) begin
                in_burst = 1;
                cur_start = cyc;
                cur_len = 0;
                cur_bad = 0;
                cur_first = out_value;
            end
            if (out_value !== 32'(cur_len - 512 + 4096 * nb_done)) cur_bad++;
            cur_last = out_value;
            cur_len++;
        end else begin
            if (out_value !== 32'd0) zero_bad++;
            if (in_burst) begin
                in_burst = 0;
                b_start.push_back(cur_start);
                b_len.push_back(cur_len);
                b_bad.push_back(cur_bad);
                b_first.push_back(cur_first);
                b_last.push_back(cur_last);
                nb_done++;
            end
        end
        if (rst) begin
            tmr = 0;
            core_done = 1'b0;
        end else begin
            core_done = 1'b0;
            if (tmr != 0) begin
                tmr--;
                if (tmr == 0) begin
                    core_done = 1'b1;
                    done_cnt++;
                    if (done_cnt % 4 == 0) done4_q.push_back(cyc);
                end
            end
            if (core_start) tmr = 7;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs_vec();
        return {out_valid, out_value, mem_we, mem_waddr, mem_wdata,
                core_start, core_frame, core_blk, core_mode, core_qp,
                rbuf_raddr, busy, proto_err};
    endfunction

    task automatic load_pattern();
        for (int p = 0; p < 16384; p++) begin
            if (p == 1000 || p == 8000 || p == 16000) begin
                in_valid_data = 1'b0;
                step();
            end
            in_valid_data = 1'b1;
            data = p[7:0];
            step();
        end
        in_valid_data = 1'b0;
        step();
        step();
    endtask

    task automatic check_writes(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_wr_count"}, wr_q.size(), 16384);
        for (int i = 0; i < wr_q.size(); i++) begin
            logic [21:0] e;
            e = {i[13:0], i[7:0]};
            if (wr_q[i] !== e) bad++;
        end
        chk({tag, "_wr_order"}, bad, 0);
        if (wr_q.size() > 0)
            chk({tag, "_wr_last"}, wr_q[wr_q.size()-1], {4'hF, 10'h3FF, 8'hFF});
        else
            chk({tag, "_wr_last"}, 0, 1);
    endtask

    task automatic run_set(input set_vec_t v, input int sidx);
        int n0, wc, i;
        n0 = nb_done;
        jobs_q.delete();
        for (i = 0; i < 3000 && busy !== 1'b0; i++) step();
        chk("idle_before_set", busy, 0);
        repeat ($urandom_range(2, 4)) step();
        for (int k = 0; k < 4; k++) begin
            in_valid_param = 1'b1;
            mode = v.beats[3-k];
            index = (k == 0) ? v.idx : 4'($urandom);
            QP = (k == 0) ? v.qp : 5'($urandom);
            step();
            in_valid_param = 1'b0;
            if (v.gaps[k]) step();
        end
        mode = 1'b0;
        if (v.proto) begin
            repeat (4) step();
            wc = wr_q.size();
            in_valid_data = 1'b1;
            data = 8'hAA;
            step();
            in_valid_data = 1'b0;
            step();
            chk("ivd_in_wait_done_ignored", wr_q.size(), wc);
            chk("proto_err_set", proto_err, 1);
            for (i = 0; i < 200 && out_valid !== 1'b1; i++) step();
            repeat (100) step();
            in_valid_param = 1'b1;
            step();
            in_valid_param = 1'b0;
            chk("proto_err_sticky", proto_err, 1);
        end
        for (i = 0; i < 3000 && nb_done == n0; i++) step();
        chk("burst_seen", nb_done, n0 + 1);
        chk("job_count", jobs_q.size(), 4);
        for (int k = 0; k < 4 && k < jobs_q.size(); k++)
            chk($sformatf("job%0d_set%0d", k, sidx), jobs_q[k],
                {2'(k), v.exp_mode[k], v.idx, v.qp});
        if (b_len.size() > n0 && done4_q.size() > n0) begin
            chk("burst_len", b_len[n0], 1024);
            chk("burst_values", b_bad[n0], 0);
            chk("burst_start", b_start[n0], done4_q[n0] + 3);
            if (sidx == 0) begin
                chk("first_value", b_first[n0], 32'hFFFFFE00);
                chk("last_value", b_last[n0], 32'd511);
            end
        end else begin
            chk("burst_record", 0, 1);
        end
        chk("out_value_zero_when_idle", zero_bad, 0);
    endtask

    set_vec_t tbl[5];

    initial begin
        tbl[0] = '{4'd5,  5'd17, 4'b1011, 4'b0010, 4'b1101, 1'b0};
        tbl[1] = '{4'd15, 5'd31, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[2] = '{4'd0,  5'd0,  4'b1111, 4'b0111, 4'b1111, 1'b0};
        tbl[3] = '{4'd10, 5'd9,  4'b0100, 4'b0101, 4'b0010, 1'b0};
        tbl[4] = '{4'd3,  5'd2,  4'b1000, 4'b0000, 4'b0001, 1'b1};

        rst = 1'b1;
        in_valid_data = 1'b0;
        data = 8'd0;
        in_valid_param = 1'b0;
        index = 4'd0;
        mode = 1'b0;
        QP = 5'd0;
        repeat (3) step();
        chk("reset_outputs", outs_vec(), 0);
        rst = 1'b0;
        step();

        for (int p = 0; p < 500; p++) begin
            in_valid_data = 1'b1;
            data = p[7:0];
            step();
        end
        in_valid_data = 1'b0;
        chk("busy_in_load", busy, 1);
        chk("write_before_reset", mem_we, 1);
        rst = 1'b1;
        step();
        chk("midload_reset_outputs", outs_vec(), 0);
        step();
        step();
        rst = 1'b0;
        step();
        wr_q.delete();

        load_pattern();
        check_writes("p1");
        chk("wait_param_not_busy", busy, 0);
        chk("proto_clear_after_load", proto_err, 0);

        for (int s = 0; s < 16; s++) begin
            set_vec_t v;
            if (s < 5) begin
                v = tbl[s];
            end else begin
                v.idx = 4'($urandom);
                v.qp = 5'($urandom);
                v.beats = 4'($urandom);
                v.gaps = 4'($urandom);
                v.proto = 1'b0;
                for (int k = 0; k < 4; k++) v.exp_mode[k] = v.beats[3-k];
            end
            if (s == 4) chk("proto_clear_before_test", proto_err, 0);
            run_set(v, s);
        end
        chk("burst_total", nb_done, 16);
        chk("proto_err_still_set", proto_err, 1);
        chk("idle_after_pattern", busy, 0);

        wr_q.delete();
        load_pattern();
        check_writes("p2");
        chk("wait_param_after_p2", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
